button_pulse_conditioner: RTL and testbench
===========================================

Name: button_pulse_conditioner

Overview:
- Upstream stage of the operand/opcode latch. That latch captures `switches` into Data_A, Data_B or Op when it sees a one-hot value on its 3-bit button bus.
- This block turns raw, bouncing, asynchronous push-button inputs into clean, synchronised, single-cycle, one-hot press pulses that drive that bus directly.
- Multi-button presses in the same cycle are rejected, so the downstream latch never sees a non-one-hot code.

Parameters:
- N_BUTTONS, 3, number of push-buttons; bit order matches the downstream bus (MSB = Data_A, middle = Data_B, LSB = Op).
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples needed to accept a level change (10 ms at 100 MHz); legal range 1 to 2^CNT_WIDTH.
- CNT_WIDTH, 20, width of each per-button debounce counter.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- buttons_raw, input, N_BUTTONS, raw asynchronous push-button levels; 1 = pressed.
- buttons, output, N_BUTTONS, registered one-hot press pulses for the downstream latch; all-zero when idle.
- buttons_level, output, N_BUTTONS, debounced held state of each button.
- collision, output, 1, one-cycle flag: two or more presses were accepted in the same cycle and suppressed.

Behaviour:
- Reset (synchronous, active-high): every register clears to 0. This covers sync flops, counters, buttons_level, buttons and collision. Reset dominates all other activity in that cycle.
- Synchronisation: per bit, a 2-FF chain: s1 <= buttons_raw[i], then s2 <= s1. Only s2 is used downstream.
- Debounce, per bit i, evaluated each clock:
  - If s2 == buttons_level[i], the counter resets to 0. Any bounce restarts the count.
  - Else, if counter == DEBOUNCE_CYCLES-1, buttons_level[i] <= s2 and the counter resets to 0 (accept).
  - Else, the counter increments.
- Counter never wraps: the accept condition fires before the terminal value.
- Accept event: press_i = accept on bit i with s2 == 1. Release events update buttons_level only and generate no pulse.
- Latency: raw sampled high at edge k gives buttons_level and the pulse set at edge k+DEBOUNCE_CYCLES+1. The pulse clears at the following edge and lasts exactly one cycle per press.
- One-hot enforcement (registered, same edge as the accept):
  - Exactly one press_i: buttons = that one-hot code, collision = 0.
  - Zero presses: buttons = 0.
  - Two or more presses in the same cycle: buttons = 0, collision = 1 for one cycle. buttons_level still updates for every accepted bit.
- Presses on different cycles never interact, even while another button is held.
- A held button never re-pulses. A new pulse requires an accepted release followed by an accepted press.
- Reset mid-count discards the partial count. A button held through reset is re-accepted DEBOUNCE_CYCLES+1 edges after reset deasserts (the sync chain needs 2 edges to refill) and produces one pulse.
- No combinational path from buttons_raw to any output.

Optional Feature:
- Macro: DEBOUNCE_BYPASS_EN.
- Defined: counters are removed and buttons_level[i] <= s2 every cycle. Pulse latency becomes 2 edges (identical to DEBOUNCE_CYCLES = 1). One-hot/collision logic is unchanged. For simulation and fast bring-up only.
- Undefined: full counter debounce as specified above.

Test Plan (DEBOUNCE_CYCLES = 4 unless noted):
- Clean press: buttons_raw = 3'b100 sampled from edge 10 and held. Required: buttons = 3'b100 only in the cycle after edge 15; buttons_level[2] = 1 from edge 15 onward; no further pulse while held.
- Bounce: bit 0 toggles 1,0,1,0 on successive cycles, then stays 1. Required: no pulse during toggling; exactly one buttons = 3'b001 pulse 5 edges after the last 0→1 sample.
- Simultaneous press: buttons_raw 3'b000 → 3'b110 on one edge. Required: buttons stays 3'b000; collision = 1 for exactly one cycle; buttons_level = 3'b110.
- Staggered press: bit 1 pressed, then bit 0 pressed 2 cycles later while bit 1 is held. Required: pulses 3'b010 and then 3'b001 two cycles apart; collision stays 0.
- Reset mid-count: bit 2 held, reset asserted for 1 cycle after 2 counted samples. Required: all outputs 0 after the reset edge; one 3'b100 pulse 5 edges after reset deasserts.
- With DEBOUNCE_BYPASS_EN: raw 3'b010 sampled at edge k. Required: buttons = 3'b010 in the cycle after edge k+2.

Source files
------------

// File: rtl/button_pulse_conditioner.sv
// Debounces raw push-buttons and emits registered one-hot single-cycle press pulses.
// Define DEBOUNCE_BYPASS_EN to drop the counters and follow the synchronised level directly.
module button_pulse_conditioner #(
   parameter int unsigned N_BUTTONS       = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_WIDTH       = 20
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N_BUTTONS-1:0] buttons_raw,
   output logic [N_BUTTONS-1:0] buttons,
   output logic [N_BUTTONS-1:0] buttons_level,
   output logic                 collision
);

   localparam logic [N_BUTTONS-1:0] One = N_BUTTONS'(1);

   logic [N_BUTTONS-1:0] s1_q, s1_d;
   logic [N_BUTTONS-1:0] s2_q, s2_d;
   logic [N_BUTTONS-1:0] level_q, level_d;
   logic [N_BUTTONS-1:0] buttons_q, buttons_d;
   logic                 collision_q, collision_d;
   logic [N_BUTTONS-1:0] accept;
   logic [N_BUTTONS-1:0] press;
   logic                 multi;

`ifndef DEBOUNCE_BYPASS_EN
   localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [N_BUTTONS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
`endif

   always_comb begin
      s1_d = buttons_raw;
      s2_d = s1_q;
`ifdef DEBOUNCE_BYPASS_EN
      accept = s2_q ^ level_q;
`else
      accept = '0;
      cnt_d  = cnt_q;
      for (int i = 0; i < int'(N_BUTTONS); i++) begin
         // Any sample matching the held level restarts the stability count.
         if (s2_q[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntLast) begin
            accept[i] = 1'b1;
            cnt_d[i]  = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
`endif
      level_d     = level_q ^ accept;
      press       = accept & s2_q;
      // More than one bit set: clearing the lowest set bit leaves something behind.
      multi       = (press & (press - One)) != '0;
      buttons_d   = multi ? '0 : press;
      collision_d = multi;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_q        <= '0;
         s2_q        <= '0;
         level_q     <= '0;
         buttons_q   <= '0;
         collision_q <= 1'b0;
`ifndef DEBOUNCE_BYPASS_EN
         cnt_q       <= '0;
`endif
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         level_q     <= level_d;
         buttons_q   <= buttons_d;
         collision_q <= collision_d;
`ifndef DEBOUNCE_BYPASS_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign buttons       = buttons_q;
   assign buttons_level = level_q;
   assign collision     = collision_q;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Scoreboard bench: expected pulses are queued with their due edge when a press is driven.
module tb_button_pulse_conditioner;

   localparam int unsigned NB = 3;
   localparam int unsigned DC = 4;
`ifdef DEBOUNCE_BYPASS_EN
   localparam int Lat    = 2;
   localparam int PreRst = 1;
`else
   localparam int Lat    = DC + 1;
   localparam int PreRst = 4;
`endif

   typedef struct {
      int          at_edge;
      logic [2:0]  btn;
      logic        coll;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset;
   logic [NB-1:0] buttons_raw;
   logic [NB-1:0] buttons;
   logic [NB-1:0] buttons_level;
   logic          collision;

   exp_t exp_q[$];
   int   edge_cnt = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   button_pulse_conditioner #(
      .N_BUTTONS      (NB),
      .DEBOUNCE_CYCLES(DC),
      .CNT_WIDTH      (3)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .buttons_raw  (buttons_raw),
      .buttons      (buttons),
      .buttons_level(buttons_level),
      .collision    (collision)
   );

   always #5 clock = ~clock;

   task automatic check_value(input string tag, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, expv, edge_cnt);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic push(input int at, input logic [2:0] b, input logic c);
      exp_t e;
      e.at_edge = at;
      e.btn     = b;
      e.coll    = c;
      exp_q.push_back(e);
   endtask

   // Any nonzero pulse or collision must match the head of the scoreboard.
   always @(posedge clock) begin
      #1;
      edge_cnt++;
      if (buttons != '0 || collision) begin
         if (exp_q.size() == 0) begin
            check_value("unexpected_pulse", {28'd0, collision, buttons}, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_value("pulse_edge", edge_cnt, e.at_edge);
            check_value("pulse_buttons", int'(buttons), int'(e.btn));
            check_value("pulse_collision", int'(collision), int'(e.coll));
         end
      end
   end

   initial begin
      int r_edge;
      reset       = 1'b1;
      buttons_raw = '0;
      tick(3);
      reset = 1'b0;
      check_value("rst_buttons", int'(buttons), 0);
      check_value("rst_level", int'(buttons_level), 0);
      check_value("rst_collision", int'(collision), 0);
      tick(2);

      // Clean press, held: one pulse only.
      buttons_raw = 3'b100;
      push(edge_cnt + 1 + Lat, 3'b100, 1'b0);
      tick(12);
      check_value("clean_level", int'(buttons_level), 4);
      buttons_raw = 3'b000;
      tick(Lat + 4);
      check_value("clean_release", int'(buttons_level), 0);

`ifndef DEBOUNCE_BYPASS_EN
      // Bounce on bit 0 before settling high.
      for (int i = 0; i < 4; i++) begin
         buttons_raw = {2'b00, ~i[0]};
         tick(1);
      end
      buttons_raw = 3'b001;
      push(edge_cnt + 1 + Lat, 3'b001, 1'b0);
      tick(12);
      check_value("bounce_level", int'(buttons_level), 1);
      buttons_raw = 3'b000;
      tick(Lat + 4);
      check_value("bounce_release", int'(buttons_level), 0);
`endif

      // Simultaneous press: collision, no pulse, both levels accepted.
      buttons_raw = 3'b110;
      push(edge_cnt + 1 + Lat, 3'b000, 1'b1);
      tick(12);
      check_value("simul_level", int'(buttons_level), 6);
      buttons_raw = 3'b000;
      tick(Lat + 4);
      check_value("simul_release", int'(buttons_level), 0);

      // Staggered press two cycles apart.
      buttons_raw = 3'b010;
      push(edge_cnt + 1 + Lat, 3'b010, 1'b0);
      tick(2);
      buttons_raw = 3'b011;
      push(edge_cnt + 1 + Lat, 3'b001, 1'b0);
      tick(12);
      check_value("stagger_level", int'(buttons_level), 3);
      buttons_raw = 3'b000;
      tick(Lat + 4);
      check_value("stagger_release", int'(buttons_level), 0);

      // Reset mid-count with bit 2 held throughout.
      buttons_raw = 3'b100;
      tick(PreRst);
      reset  = 1'b1;
      r_edge = edge_cnt + 1;
      tick(1);
      check_value("midrst_buttons", int'(buttons), 0);
      check_value("midrst_level", int'(buttons_level), 0);
      check_value("midrst_collision", int'(collision), 0);
      reset = 1'b0;
      push(r_edge + 1 + Lat, 3'b100, 1'b0);
      tick(12);
      check_value("midrst_held_level", int'(buttons_level), 4);
      buttons_raw = 3'b000;
      tick(Lat + 4);

      check_value("pending_pulses", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
